// File: rtl/seq_mult4x4_core2x2.sv
// Sequential unsigned 4x4 multiplier: one 2x2 multiplier core accumulates four
// shifted partial products into an 8-bit accumulator under a start/done FSM.

module mult2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);
  assign p = {2'b00, x} * {2'b00, y};
endmodule

module mux2to1 #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

module mux3to1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = '0;
    endcase
  end
endmodule

module seq_mult4x4_core2x2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       done,
  output logic [7:0] out
);
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StP0   = 3'd2,
    StP1   = 3'd3,
    StP2   = 3'd4,
    StP3   = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] reg_a_q, reg_a_d;
  logic [3:0] reg_b_q, reg_b_d;
  logic [7:0] acc_q, acc_d;

  logic       sel_a, sel_b;
  logic [1:0] sel_shift;
  logic [1:0] op_a, op_b;
  logic [3:0] prod;
  logic [7:0] shifted;

  mux2to1 #(.WIDTH(2)) u_mux_a (
    .d0  (reg_a_q[1:0]),
    .d1  (reg_a_q[3:2]),
    .sel (sel_a),
    .y   (op_a)
  );

  mux2to1 #(.WIDTH(2)) u_mux_b (
    .d0  (reg_b_q[1:0]),
    .d1  (reg_b_q[3:2]),
    .sel (sel_b),
    .y   (op_b)
  );

  mult2x2 u_mult (
    .x (op_a),
    .y (op_b),
    .p (prod)
  );

  mux3to1 #(.WIDTH(8)) u_mux_shift (
    .d0  ({4'b0000, prod}),
    .d1  ({2'b00, prod, 2'b00}),
    .d2  ({prod, 4'b0000}),
    .sel (sel_shift),
    .y   (shifted)
  );

  always_comb begin
    state_d   = state_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    acc_d     = acc_q;
    sel_a     = 1'b0;
    sel_b     = 1'b0;
    sel_shift = 2'b11;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        reg_a_d = a;
        reg_b_d = b;
        acc_d   = 8'h00;
        state_d = StP0;
      end
      StP0: begin
        sel_shift = 2'b00;
        acc_d     = acc_q + shifted;
        state_d   = StP1;
      end
      StP1: begin
        sel_a     = 1'b1;
        sel_shift = 2'b01;
        acc_d     = acc_q + shifted;
        state_d   = StP2;
      end
      StP2: begin
        sel_b     = 1'b1;
        sel_shift = 2'b01;
        acc_d     = acc_q + shifted;
        state_d   = StP3;
      end
      StP3: begin
        sel_a     = 1'b1;
        sel_b     = 1'b1;
        sel_shift = 2'b10;
        acc_d     = acc_q + shifted;
        state_d   = StIdle;
      end
      default: state_d = StIdle;  // unused encodings recover to idle
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      reg_a_q <= 4'h0;
      reg_b_q <= 4'h0;
      acc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      acc_q   <= acc_d;
    end
  end

  assign done = (state_q == StIdle);
  assign out  = acc_q;
endmodule

// File: tb/tb_seq_mult4x4_core2x2.sv
// Directed bench for seq_mult4x4_core2x2: vector table plus hand-written
// sequences for reset, operand stability and back-to-back operation.

module tb_seq_mult4x4_core2x2;
  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       done;
  logic [7:0] out;

  int checks;
  int failures;

  seq_mult4x4_core2x2 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] prod;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one multiply from IDLE, wait for done, check latency and product.
  task automatic do_mult(input logic [3:0] ta, input logic [3:0] tb_v,
                         input logic [7:0] expected, input bit scramble, input string name);
    int lat;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (done == 1'b0 && lat < 20) begin
      tick();
      lat++;
      if (scramble) begin
        a = 4'($urandom);
        b = 4'($urandom);
      end
    end
    check({name, "_latency"}, lat, 5);
    check({name, "_out"}, int'(out), int'(expected));
  endtask

  initial begin
    logic [3:0] pa[3];
    logic [3:0] pb[3];
    logic [7:0] pp[3];
    int lat;
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    a        = 4'h0;
    b        = 4'h0;

    vecs[0] = '{4'd10, 4'd6,  8'd60};
    vecs[1] = '{4'd15, 4'd15, 8'd225};
    vecs[2] = '{4'd0,  4'd13, 8'd0};
    vecs[3] = '{4'd1,  4'd1,  8'd1};
    vecs[4] = '{4'd2,  4'd3,  8'd6};
    vecs[5] = '{4'd15, 4'd1,  8'd15};
    vecs[6] = '{4'd8,  4'd12, 8'd96};

    // Power-up reset
    rst = 1'b1;
    #3;
    check("reset_out", int'(out), 0);
    check("reset_done", int'(done), 1);
    #14;
    rst = 1'b0;
    repeat (3) tick();
    check("idle_hold_done", int'(done), 1);
    check("idle_hold_out", int'(out), 0);

    for (int i = 0; i < 7; i++) begin
      do_mult(vecs[i].va, vecs[i].vb, vecs[i].prod, 1'b0, $sformatf("vec%0d", i));
    end

    // Result holds in IDLE with start low
    repeat (3) tick();
    check("hold_out", int'(out), 96);
    check("hold_done", int'(done), 1);

    do_mult(4'd11, 4'd9, 8'd99, 1'b1, "stability");

    // Async reset mid-cycle while idle with a nonzero result
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", int'(out), 0);
    check("async_rst_done", int'(done), 1);
    #3;
    rst = 1'b0;
    tick();

    // Back-to-back with start held high
    pa[0] = 4'd4;  pb[0] = 4'd7;  pp[0] = 8'd28;
    pa[1] = 4'd3;  pb[1] = 4'd5;  pp[1] = 8'd15;
    pa[2] = 4'd12; pb[2] = 4'd12; pp[2] = 8'd144;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = pa[i];
      b = pb[i];
      tick();
      check($sformatf("b2b%0d_done_pulse", i), int'(done), 0);
      lat = 0;
      while (done == 1'b0 && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("b2b%0d_latency", i), lat, 5);
      check($sformatf("b2b%0d_out", i), int'(out), int'(pp[i]));
    end
    start = 1'b0;
    tick();

    // Reset during P2
    a     = 4'd9;
    b     = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid_op_busy", int'(done), 0);
    check("mid_op_partial", int'(out), 9);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out", int'(out), 0);
    check("mid_rst_done", int'(done), 1);
    #3;
    rst = 1'b0;
    tick();
    check("post_rst_done", int'(done), 1);
    check("post_rst_out", int'(out), 0);
    do_mult(4'd6, 4'd5, 8'd30, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_mult4x4_core2x2.md
Name: seq_mult4x4_core2x2

Overview:
- Sequential unsigned 4x4 multiplier producing an 8-bit product.
- The datapath uses one combinational 2x2 multiplier (the Mult2x2 core), a 2:1 operand-select mux (Mux2to1) per operand, and a 3:1 shift-select mux (Mux3to1) feeding an 8-bit accumulator.
- It forms four 2-bit partial products over four accumulate cycles under a small FSM with a start/done handshake.
- Used as the multiply-accumulate building block of the MAC datapath.

Parameters:
- None. Widths are fixed: operands 4 bits, product 8 bits.
- Internal mux submodules take a width parameter: Mux2to1 WIDTH default 2, Mux3to1 WIDTH default 8.

Ports:
- clk  input  1  Sole clock; all state updates on its rising edge.
- rst  input  1  Asynchronous, active-high reset.
- start  input  1  Request a multiply; sampled only in IDLE.
- a  input  4  Unsigned multiplicand; captured on the LOAD edge.
- b  input  4  Unsigned multiplier; captured on the LOAD edge.
- done  output  1  High exactly while the FSM is in IDLE.
- out  output  8  Accumulator value; holds the final product in IDLE.

Behaviour:
- Reset is asynchronous and active-high. It forces state = IDLE, operand registers = 0, accumulator = 0. Consequently out = 0 and done = 1 while reset is held and after release.
- States and transitions:
  - IDLE: stay while start = 0; go to LOAD when start = 1.
  - LOAD: capture a and b into registers; clear the accumulator; go to P0.
  - P0: acc += aL*bL (shift 0); go to P1.
  - P1: acc += aH*bL << 2; go to P2.
  - P2: acc += aL*bH << 2; go to P3.
  - P3: acc += aH*bH << 4; go to IDLE.
  - aL/aH are reg_a[1:0] and reg_a[3:2]; likewise bL/bH for reg_b.
- Datapath:
  - The operand muxes select the register halves, never the live inputs.
  - Mult2x2 is purely combinational: 2-bit x 2-bit unsigned to 4-bit, maximum 9.
  - Mux3to1 selects the shifted product: sel 00 gives {4'b0, p}, 01 gives {2'b0, p, 2'b0}, 10 gives {p, 4'b0}, 11 gives 8'h00.
  - The accumulator adds modulo 256. Overflow cannot occur: max 15*15 = 225, and every partial sum is at most 225.
- Latency: with start high at edge 0 (in IDLE), the FSM is in LOAD after edge 0 and in IDLE after edge 5. done is 0 for 5 cycles and returns high with out = a*b valid.
- During P0–P3, out shows partial sums; it is not valid until done = 1.
- Changes to a/b after the LOAD edge do not affect the result.
- start is ignored outside IDLE.
- If start is held high, a new operation begins the cycle after done rises, so done is a 1-cycle pulse between operations.
- out holds the last product through IDLE until the next LOAD clears it. Reset at power-up gives out = 0.
- Reset asserted mid-operation aborts immediately to IDLE with out = 0 and done = 1; no partial result is retained.
- No undefined states: with 3-bit encoding, the unused codes transition to IDLE.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out = 8'h00 and done = 1 immediately; after release the FSM stays in IDLE with start = 0.
- Basic: a = 4'b1010, b = 4'b0110, pulse start -> done falls for 5 cycles, then done = 1 and out = 60 (8'h3C).
- Corner values:
  - a = 15, b = 15 -> out = 225 (8'hE1).
  - a = 0, b = 13 -> out = 0.
  - a = 1, b = 1 -> out = 1.
- Operand stability: a = 11, b = 9; change a/b to random values every cycle after the LOAD edge -> out = 99.
- Back-to-back: hold start = 1 with a/b updated each done pulse over pairs (4, 7), (3, 5), (12, 12) -> out = 28, 15, 144 in turn; done is high for exactly 1 cycle between operations.
- Reset mid-operation: assert rst in state P2 -> out = 0 and done = 1 asynchronously; a subsequent start with a = 6, b = 5 -> out = 30.
